// File: rtl/freelist_ctrl.sv
// ============================================================================
// Module   : freelist_ctrl
// Brief    : In-order per-way physical-register grant control plus a
//            multi-cycle checkpoint-map sweep for branch recovery.
//            Optional macro FREELIST_CTRL_STATS_EN adds stall/recovery counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freelist_ctrl #(
    parameter int N_PHYS_REG = 64,
    parameter int N_ARCH_REG = 32,
    parameter int WAYS       = 2,
    parameter int SWEEP_K    = 8,
    parameter int PRW        = $clog2(N_PHYS_REG)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [WAYS-1:0]                    dispatch_req,
    input  logic [WAYS-1:0]                    retire_valid,
    input  logic                               br_recover_enable,
    input  logic [N_ARCH_REG*PRW-1:0]          recovery_map,
    output logic [WAYS-1:0]                    dispatch_grant,
    output logic                               dispatch_stall,
    output logic                               retire_hold,
    output logic                               rec_valid,
    output logic                               rec_clear_all,
    output logic [SWEEP_K*PRW-1:0]             rec_idx,
    output logic                               rec_busy,
`ifdef FREELIST_CTRL_STATS_EN
    output logic [31:0]                        stat_stall_cycles,
    output logic [31:0]                        stat_recoveries,
`endif
    output logic [$clog2(N_PHYS_REG+1)-1:0]    free_count
);

    localparam int c_CNT_W     = $clog2(N_PHYS_REG + 1);
    localparam int c_N_BEATS   = N_ARCH_REG / SWEEP_K;
    localparam int c_BEAT_W    = (c_N_BEATS > 1) ? $clog2(c_N_BEATS) : 1;
    localparam int c_BEAT_BITS = SWEEP_K * PRW;

    localparam logic [c_CNT_W-1:0]  c_FREE_INIT = c_CNT_W'(N_PHYS_REG - N_ARCH_REG);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_N_BEATS - 1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SWEEP = 1'b1;

    logic [0:0]                r_state;
    logic [N_ARCH_REG*PRW-1:0] r_snap;
    logic [c_BEAT_W-1:0]       r_beat;
    logic [c_CNT_W-1:0]        r_free_count;

    logic [WAYS-1:0]           w_grant;
    logic [c_CNT_W-1:0]        w_used;
    logic                      w_blocked;
    logic [c_CNT_W:0]          w_free_next;
    logic                      w_sweep;
    logic                      w_last_beat;

    assign w_sweep     = (r_state == c_S_SWEEP);
    assign w_last_beat = (r_beat == c_LAST_BEAT);

    // In-order grant against the registered count; a denied requester blocks
    // every higher way, an idle way does not.
    always_comb begin
        w_grant   = '0;
        w_used    = '0;
        w_blocked = 1'b0;
        if (!w_sweep && !br_recover_enable) begin
            for (int i = 0; i < WAYS; i++) begin
                if (dispatch_req[i] && !w_blocked) begin
                    if (w_used < r_free_count) begin
                        w_grant[i] = 1'b1;
                        w_used     = w_used + c_CNT_W'(1);
                    end else begin
                        w_blocked  = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_free_next = {1'b0, r_free_count};
        for (int i = 0; i < WAYS; i++) begin
            w_free_next = w_free_next + (c_CNT_W+1)'(retire_valid[i])
                                      - (c_CNT_W+1)'(w_grant[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_free_count <= c_FREE_INIT;
            r_snap       <= '0;
            r_beat       <= '0;
        end else if (!w_sweep) begin
            if (br_recover_enable) begin
                r_state <= c_S_SWEEP;
                r_snap  <= recovery_map;
                r_beat  <= '0;
            end else begin
                r_free_count <= w_free_next[c_CNT_W-1:0];
            end
        end else begin
            if (br_recover_enable) begin
                r_snap <= recovery_map;
                r_beat <= '0;
            end else if (w_last_beat) begin
                r_state      <= c_S_IDLE;
                r_beat       <= '0;
                r_free_count <= c_FREE_INIT;
            end else begin
                r_beat <= r_beat + c_BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !w_sweep && !br_recover_enable) begin
            assert (w_free_next <= {1'b0, c_FREE_INIT});
        end
    end

    assign dispatch_grant = w_grant;
    assign dispatch_stall = w_sweep | br_recover_enable | (|(dispatch_req & ~w_grant));
    assign retire_hold    = w_sweep;
    assign rec_valid      = w_sweep;
    assign rec_busy       = w_sweep;
    assign rec_clear_all  = w_sweep && (r_beat == '0);
    assign rec_idx        = w_sweep ? r_snap[int'(r_beat)*c_BEAT_BITS +: c_BEAT_BITS] : '0;
    assign free_count     = r_free_count;

`ifdef FREELIST_CTRL_STATS_EN
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_rec;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_stall <= '0;
            r_stat_rec   <= '0;
        end else begin
            if (dispatch_stall)    r_stat_stall <= r_stat_stall + 32'd1;
            if (br_recover_enable) r_stat_rec   <= r_stat_rec + 32'd1;
        end
    end

    assign stat_stall_cycles = r_stat_stall;
    assign stat_recoveries   = r_stat_rec;
`endif

endmodule

`default_nettype wire

// File: tb/tb_freelist_ctrl.sv
// ============================================================================
// Module   : tb_freelist_ctrl
// Brief    : Directed scenarios plus randomized run against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freelist_ctrl;

    localparam int N_PHYS_REG = 64;
    localparam int N_ARCH_REG = 32;
    localparam int WAYS       = 2;
    localparam int SWEEP_K    = 8;
    localparam int PRW        = 6;
    localparam int CW         = 7;
    localparam int N_BEATS    = N_ARCH_REG / SWEEP_K;
    localparam int BEAT_BITS  = SWEEP_K * PRW;
    localparam int FREE_INIT  = N_PHYS_REG - N_ARCH_REG;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [WAYS-1:0]           dispatch_req;
    logic [WAYS-1:0]           retire_valid;
    logic                      br_recover_enable;
    logic [N_ARCH_REG*PRW-1:0] recovery_map;
    logic [WAYS-1:0]           dispatch_grant;
    logic                      dispatch_stall;
    logic                      retire_hold;
    logic                      rec_valid;
    logic                      rec_clear_all;
    logic [BEAT_BITS-1:0]      rec_idx;
    logic                      rec_busy;
    logic [CW-1:0]             free_count;
`ifdef FREELIST_CTRL_STATS_EN
    logic [31:0]               stat_stall_cycles;
    logic [31:0]               stat_recoveries;
`endif

    freelist_ctrl #(
        .N_PHYS_REG (N_PHYS_REG),
        .N_ARCH_REG (N_ARCH_REG),
        .WAYS       (WAYS),
        .SWEEP_K    (SWEEP_K),
        .PRW        (PRW)
    ) u_dut (
        .clock             (clock),
        .reset             (reset),
        .dispatch_req      (dispatch_req),
        .retire_valid      (retire_valid),
        .br_recover_enable (br_recover_enable),
        .recovery_map      (recovery_map),
        .dispatch_grant    (dispatch_grant),
        .dispatch_stall    (dispatch_stall),
        .retire_hold       (retire_hold),
        .rec_valid         (rec_valid),
        .rec_clear_all     (rec_clear_all),
        .rec_idx           (rec_idx),
        .rec_busy          (rec_busy),
`ifdef FREELIST_CTRL_STATS_EN
        .stat_stall_cycles (stat_stall_cycles),
        .stat_recoveries   (stat_recoveries),
`endif
        .free_count        (free_count)
    );

    always #5 clock = ~clock;

    // {grant[1:0], stall, hold, valid, clear_all, busy}
    logic [6:0] ctl;
    assign ctl = {dispatch_grant, dispatch_stall, retire_hold, rec_valid, rec_clear_all, rec_busy};

    int n_checks = 0;
    int n_fail   = 0;
    int map_arr [N_ARCH_REG];

    typedef struct packed {
        logic                 clr;
        logic [BEAT_BITS-1:0] idx;
    } beat_t;

    function automatic logic [N_ARCH_REG*PRW-1:0] pack_map();
        logic [N_ARCH_REG*PRW-1:0] v;
        for (int a = 0; a < N_ARCH_REG; a++) v[a*PRW +: PRW] = PRW'(map_arr[a]);
        return v;
    endfunction

    function automatic logic [N_ARCH_REG*PRW-1:0] offset_map(input int off);
        for (int a = 0; a < N_ARCH_REG; a++) map_arr[a] = a + off;
        return pack_map();
    endfunction

    // Consecutive physical indices first..first+SWEEP_K-1, entry 0 in the low bits.
    function automatic logic [BEAT_BITS-1:0] run_beat(input int first);
        logic [BEAT_BITS-1:0] v;
        for (int j = 0; j < SWEEP_K; j++) v[j*PRW +: PRW] = PRW'(first + j);
        return v;
    endfunction

    task automatic drive(input logic [1:0] req, input logic [1:0] ret, input logic br);
        dispatch_req      = req;
        retire_valid      = ret;
        br_recover_enable = br;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'b00, 2'b00, 1'b0);
        recovery_map = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (free_count !== CW'(FREE_INIT)) begin
            n_fail++;
            $display("FAIL reset_free_count: got %0d want %0d", free_count, FREE_INIT);
        end
        n_checks++;
        if (ctl !== 7'b0 || rec_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctl=%b idx=%h want ctl=0 idx=0", ctl, rec_idx);
        end
        @(negedge clock);
    endtask

    task automatic test_fill();
        for (int k = 0; k < FREE_INIT / 2; k++) begin
            drive(2'b11, 2'b00, 1'b0);
            #1;
            n_checks++;
            if (free_count !== CW'(FREE_INIT - 2*k) || ctl !== 7'b11_00000) begin
                n_fail++;
                $display("FAIL fill_step%0d: got fc=%0d ctl=%b want fc=%0d ctl=1100000",
                         k, free_count, ctl, FREE_INIT - 2*k);
            end
            @(negedge clock);
        end
        drive(2'b11, 2'b00, 1'b0);
        #1;
        n_checks++;
        if (free_count !== CW'(0) || ctl !== 7'b00_10000) begin
            n_fail++;
            $display("FAIL fill_empty: got fc=%0d ctl=%b want fc=0 ctl=0010000", free_count, ctl);
        end
        @(negedge clock);
    endtask

    task automatic test_partial();
        drive(2'b00, 2'b01, 1'b0);
        #1;
        @(negedge clock);
        drive(2'b11, 2'b00, 1'b0);
        #1;
        n_checks++;
        if (free_count !== CW'(1) || ctl !== 7'b01_10000) begin
            n_fail++;
            $display("FAIL partial_one_free: got fc=%0d ctl=%b want fc=1 ctl=0110000", free_count, ctl);
        end
        @(negedge clock);
        drive(2'b00, 2'b01, 1'b0);
        #1;
        n_checks++;
        if (free_count !== CW'(0)) begin
            n_fail++;
            $display("FAIL partial_after_grant: got fc=%0d want 0", free_count);
        end
        @(negedge clock);
        drive(2'b10, 2'b00, 1'b0);
        #1;
        n_checks++;
        if (free_count !== CW'(1) || ctl !== 7'b10_00000) begin
            n_fail++;
            $display("FAIL partial_upper_way: got fc=%0d ctl=%b want fc=1 ctl=1000000", free_count, ctl);
        end
        @(negedge clock);
    endtask

    task automatic test_retire_conservative();
        drive(2'b11, 2'b11, 1'b0);
        #1;
        n_checks++;
        if (free_count !== CW'(0) || ctl !== 7'b00_10000) begin
            n_fail++;
            $display("FAIL retire_same_cycle: got fc=%0d ctl=%b want fc=0 ctl=0010000", free_count, ctl);
        end
        @(negedge clock);
        drive(2'b11, 2'b00, 1'b0);
        #1;
        n_checks++;
        if (free_count !== CW'(2) || ctl !== 7'b11_00000) begin
            n_fail++;
            $display("FAIL retire_next_cycle: got fc=%0d ctl=%b want fc=2 ctl=1100000", free_count, ctl);
        end
        @(negedge clock);
    endtask

    task automatic test_sweep();
        recovery_map = offset_map(10);
        drive(2'b11, 2'b11, 1'b1);
        #1;
        n_checks++;
        if (ctl !== 7'b00_10000) begin
            n_fail++;
            $display("FAIL sweep_capture: got ctl=%b want 0010000", ctl);
        end
        @(negedge clock);
        br_recover_enable = 1'b0;
        for (int b = 0; b < N_BEATS; b++) begin
            #1;
            n_checks++;
            if (ctl !== {2'b00, 3'b111, (b == 0), 1'b1} || rec_idx !== run_beat(10 + b*SWEEP_K)) begin
                n_fail++;
                $display("FAIL sweep_beat%0d: got ctl=%b idx=%h want idx=%h", b, ctl, rec_idx,
                         run_beat(10 + b*SWEEP_K));
            end
            @(negedge clock);
        end
        retire_valid = 2'b00;
        #1;
        n_checks++;
        if (free_count !== CW'(FREE_INIT) || ctl !== 7'b11_00000) begin
            n_fail++;
            $display("FAIL sweep_done: got fc=%0d ctl=%b want fc=%0d ctl=1100000", free_count, ctl, FREE_INIT);
        end
        @(negedge clock);
    endtask

    task automatic test_restart();
        recovery_map = offset_map(10);
        drive(2'b00, 2'b00, 1'b1);
        #1;
        @(negedge clock);
        br_recover_enable = 1'b0;
        repeat (2) @(negedge clock);
        recovery_map = offset_map(20);
        br_recover_enable = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 7'b00_11101 || rec_idx !== run_beat(10 + 2*SWEEP_K)) begin
            n_fail++;
            $display("FAIL restart_old_beat2: got ctl=%b idx=%h", ctl, rec_idx);
        end
        @(negedge clock);
        br_recover_enable = 1'b0;
        for (int b = 0; b < N_BEATS; b++) begin
            #1;
            n_checks++;
            if (rec_valid !== 1'b1 || rec_clear_all !== (b == 0) || rec_idx !== run_beat(20 + b*SWEEP_K)) begin
                n_fail++;
                $display("FAIL restart_beat%0d: got valid=%b clr=%b idx=%h want idx=%h", b, rec_valid,
                         rec_clear_all, rec_idx, run_beat(20 + b*SWEEP_K));
            end
            @(negedge clock);
        end
        #1;
        n_checks++;
        if (free_count !== CW'(FREE_INIT) || ctl !== 7'b0) begin
            n_fail++;
            $display("FAIL restart_done: got fc=%0d ctl=%b want fc=%0d ctl=0", free_count, ctl, FREE_INIT);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_midsweep();
        recovery_map = offset_map(5);
        drive(2'b00, 2'b00, 1'b1);
        #1;
        @(negedge clock);
        br_recover_enable = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (rec_busy !== 1'b1 || rec_clear_all !== 1'b0) begin
            n_fail++;
            $display("FAIL midsweep_beat1: got busy=%b clr=%b want busy=1 clr=0", rec_busy, rec_clear_all);
        end
        @(negedge clock);
        reset = 1'b0;
        dispatch_req = 2'b11;
        #1;
        n_checks++;
        if (free_count !== CW'(FREE_INIT) || ctl !== 7'b11_00000) begin
            n_fail++;
            $display("FAIL midsweep_reset: got fc=%0d ctl=%b want fc=%0d ctl=1100000", free_count, ctl, FREE_INIT);
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        beat_t          q[$];
        beat_t          bt;
        int             m_free;
        int             avail;
        bit             denied;
        logic           r_rst, r_br;
        logic [1:0]     req, ret, e_grant;
        logic [6:0]     e_ctl;
        logic [BEAT_BITS-1:0] e_idx;
`ifdef FREELIST_CTRL_STATS_EN
        logic [31:0]    m_stalls = '0;
        logic [31:0]    m_recs   = '0;
`endif
        reset = 1'b1;
        drive(2'b00, 2'b00, 1'b0);
        #1;
        @(negedge clock);
        reset  = 1'b0;
        m_free = FREE_INIT;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_br  = ($urandom_range(0, 19) == 0);
            req   = 2'($urandom);
            ret   = 2'($urandom);
            while (m_free + $countones(ret) > FREE_INIT) ret = ret & (ret - 2'd1);
            for (int a = 0; a < N_ARCH_REG; a++) map_arr[a] = $urandom_range(0, N_PHYS_REG - 1);
            recovery_map = pack_map();
            reset = r_rst;
            drive(req, ret, r_br);
            #1;
            e_grant = 2'b00;
            e_idx   = '0;
            if (q.size() > 0) begin
                e_ctl = {2'b00, 3'b111, q[0].clr, 1'b1};
                e_idx = q[0].idx;
            end else if (r_br) begin
                e_ctl = 7'b00_10000;
            end else begin
                avail  = m_free;
                denied = 1'b0;
                for (int i = 0; i < WAYS; i++) begin
                    if (req[i]) begin
                        if (!denied && avail > 0) begin
                            e_grant[i] = 1'b1;
                            avail--;
                        end else begin
                            denied = 1'b1;
                        end
                    end
                end
                e_ctl = {e_grant, |(req & ~e_grant), 4'b0000};
            end
            n_checks++;
            if (ctl !== e_ctl || rec_idx !== e_idx) begin
                n_fail++;
                $display("FAIL random_out cyc%0d: got ctl=%b idx=%h want ctl=%b idx=%h", cyc, ctl, rec_idx, e_ctl, e_idx);
            end
            n_checks++;
            if (free_count !== CW'(m_free)) begin
                n_fail++;
                $display("FAIL random_free cyc%0d: got %0d want %0d", cyc, free_count, m_free);
            end
`ifdef FREELIST_CTRL_STATS_EN
            n_checks++;
            if (stat_stall_cycles !== m_stalls || stat_recoveries !== m_recs) begin
                n_fail++;
                $display("FAIL random_stats cyc%0d: got %0d/%0d want %0d/%0d", cyc,
                         stat_stall_cycles, stat_recoveries, m_stalls, m_recs);
            end
            if (r_rst) begin
                m_stalls = '0;
                m_recs   = '0;
            end else begin
                m_stalls = m_stalls + 32'(e_ctl[4]);
                m_recs   = m_recs + 32'(r_br);
            end
`endif
            if (r_rst) begin
                m_free = FREE_INIT;
                q.delete();
            end else if (r_br) begin
                q.delete();
                for (int b = 0; b < N_BEATS; b++) begin
                    bt.clr = (b == 0);
                    for (int j = 0; j < SWEEP_K; j++) bt.idx[j*PRW +: PRW] = PRW'(map_arr[b*SWEEP_K + j]);
                    q.push_back(bt);
                end
            end else if (q.size() > 0) begin
                void'(q.pop_front());
                if (q.size() == 0) m_free = FREE_INIT;
            end else begin
                m_free = m_free + $countones(ret) - $countones(e_grant);
            end
            @(negedge clock);
        end
        reset = 1'b0;
        drive(2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_partial();
        test_retire_conservative();
        test_sweep();
        test_restart();
        test_reset_midsweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/freelist_ctrl.md
Name: freelist_ctrl

Overview:
- Controller in front of the physical-register free list.
- Tracks the number of free physical registers and grants per-way allocation requests from dispatch, in order. A granted way drives the free list's new_pr_en.
- Replaces single-cycle branch recovery with a multi-cycle sweep. The sweep streams the checkpoint map table to the free list K entries per cycle, and stalls dispatch and holds retire while it runs.

Parameters:
- N_PHYS_REG, 64, number of physical registers.
- N_ARCH_REG, 32, number of architectural registers; must be a multiple of SWEEP_K.
- WAYS, 2, superscalar width.
- SWEEP_K, 8, map entries emitted per sweep cycle.
- PRW, $clog2(N_PHYS_REG), physical register index width.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- dispatch_req  in  WAYS  way i wants a new physical register.
- retire_valid  in  WAYS  way i retires and frees its told register.
- br_recover_enable  in  1  mispredict; load recovery_map.
- recovery_map  in  N_ARCH_REG*PRW  checkpoint map; entry a at bits [a*PRW +: PRW].
- dispatch_grant  out  WAYS  allocation granted (to freelist new_pr_en).
- dispatch_stall  out  1  some requested way was not granted, or a sweep is active.
- retire_hold  out  1  retire must not present frees this cycle.
- rec_valid  out  1  sweep beat valid.
- rec_clear_all  out  1  first beat: free list sets all bits free before applying this beat.
- rec_idx  out  SWEEP_K*PRW  physical indices to mark allocated this beat.
- rec_busy  out  1  FSM not IDLE.
- free_count  out  $clog2(N_PHYS_REG+1)  registered free-register count.

Behaviour:

Reset:
- Synchronous; wins over all inputs, including during a sweep.
- State ← IDLE.
- free_count ← N_PHYS_REG-N_ARCH_REG.
- Snapshot register and beat counter ← 0.
- All outputs 0 in the cycle after reset.

FSM states: IDLE, SWEEP.

IDLE:
- Grants are combinational on the registered free_count; frees retiring this cycle are not counted, so the grant is conservative.
- dispatch_grant[i] = dispatch_req[i] AND every lower requesting way granted AND (grants in ways 0..i) ≤ free_count.
- A non-requesting lower way does not block a higher way.
- A denied way blocks all higher ways.
- free_count_next = free_count + popcount(retire_valid) − popcount(dispatch_grant). The result never exceeds N_PHYS_REG-N_ARCH_REG; a violation is an assertion failure.
- dispatch_stall = |(dispatch_req & ~dispatch_grant).
- retire_hold = 0.

IDLE → SWEEP on br_recover_enable:
- Capture recovery_map into the snapshot register.
- beat ← 0.
- Same-cycle outputs: dispatch_grant = 0, dispatch_stall = 1. retire_valid is ignored; the retire stage is required to see retire_hold next cycle.

SWEEP, beat b in 0 .. N_ARCH_REG/SWEEP_K − 1:
- rec_valid = 1.
- rec_idx = snapshot entries b*SWEEP_K .. b*SWEEP_K+SWEEP_K−1.
- rec_clear_all = (b == 0).
- rec_busy = 1, dispatch_stall = 1, dispatch_grant = 0, retire_hold = 1.
- retire_valid is ignored.

SWEEP → IDLE after the last beat:
- free_count ← N_PHYS_REG-N_ARCH_REG.
- Dispatch resumes the following cycle.
- Sweep latency is N_ARCH_REG/SWEEP_K cycles after the capture cycle (4 at defaults).

br_recover_enable during SWEEP:
- Restart: recapture the snapshot, beat ← 0.
- The next cycle is a clear_all beat.
- Rest of the old sweep is discarded.

Outputs in IDLE: rec_valid, rec_clear_all, rec_busy and rec_idx are all 0.

Optional Feature:
- Macro: FREELIST_CTRL_STATS_EN.
- When defined, add two 32-bit outputs, both reset to 0 and wrapping at 2^32:
  - stat_stall_cycles: increments on each cycle with dispatch_stall=1.
  - stat_recoveries: increments on each br_recover_enable, restarts included.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then req=2'b11 with no retire → grant=11 each cycle. free_count goes 32, 30, 28 … 0. With free_count=0: grant=00, stall=1.
- free_count=1, req=11 → grant=01, stall=1, next free_count=0. Then free_count=1, req=10 → grant=10.
- free_count=0, retire_valid=11, req=11 → grant=00 that cycle. Next cycle free_count=2, grant=11.
- br_recover_enable with map entry a = a+10:
  - 4 beats follow; beat0 has rec_clear_all=1, rec_idx={10..17}; beat3 has rec_idx={34..41}.
  - stall=1 and retire_hold=1 throughout.
  - Then IDLE with free_count=32.
- Second br_recover_enable on beat 2 with map a = a+20 → beat counter restarts. The next beat has clear_all=1, rec_idx={20..27}; 4 further beats in total.
- reset asserted on beat 1 of a sweep → next cycle rec_busy=0, rec_valid=0, free_count=32. Then req=11 → grant=11.
